// File: rtl/branch_control_unit.sv
// Control FSM sequencing fetch (T0-T2) and conditional-branch execution (T3-T6) for a
// single-bus datapath; all strobes are registered from the next state.
module branch_control_unit #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] OPC_BRANCH = 5'b10010,
  parameter int         COND_LSB   = 19,
  parameter int         WAIT_MAX   = 15
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] IR,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic                  PCout,
  output logic                  MARin,
  output logic                  IncPC,
  output logic                  Zin,
  output logic                  Read,
  output logic                  MDRin,
  output logic                  PCin,
  output logic                  MDRout,
  output logic                  IRin,
  output logic                  Gra,
  output logic                  Rout,
  output logic                  CONin,
  output logic                  Yin,
  output logic                  Cout,
  output logic                  ZLOout,
  output logic                  CON,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic                  timeout
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_END = 4'd8
  } state_t;

  state_t          state_r;
  state_t          nxt_s;
  logic [CW-1:0]   wait_cnt_r;
  logic            pcin_r;
  logic [4:0]      opcode_s;
  logic [1:0]      c2_s;
  logic            stall_limit_s;

  function automatic logic eval_cond(input logic [1:0] c2, input logic [DATA_WIDTH-1:0] v);
    logic r;
    case (c2)
      2'b00:   r = (v == {DATA_WIDTH{1'b0}});
      2'b01:   r = (v != {DATA_WIDTH{1'b0}});
      2'b10:   r = ~v[DATA_WIDTH-1];
      2'b11:   r = v[DATA_WIDTH-1];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign opcode_s      = IR[DATA_WIDTH-1 -: 5];
  assign c2_s          = IR[COND_LSB+1:COND_LSB];
  assign stall_limit_s = (wait_cnt_r == CW'(WAIT_MAX - 1));

  // PC load in T1 must coincide with the cycle the read data is valid, so it is
  // qualified by mem_ready on top of the registered Read strobe.
  assign PCin = pcin_r | (Read & mem_ready);

  // Next-state decode; T3 falls back to IDLE when CONin was withheld (illegal opcode).
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      S_IDLE:  nxt_s = start ? S_T0 : S_IDLE;
      S_T0:    nxt_s = S_T1;
      S_T1: begin
        if (mem_ready)          nxt_s = S_T2;
        else if (stall_limit_s) nxt_s = S_IDLE;
        else                    nxt_s = S_T1;
      end
      S_T2:    nxt_s = S_T3;
      S_T3:    nxt_s = CONin ? S_T4 : S_IDLE;
      S_T4:    nxt_s = S_T5;
      S_T5:    nxt_s = S_T6;
      S_T6:    nxt_s = S_END;
      S_END:   nxt_s = start ? S_T0 : S_IDLE;
      default: nxt_s = S_IDLE;
    endcase
  end

  // State, wait counter, condition flag and registered Moore strobes.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= {CW{1'b0}};
      CON        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      timeout    <= 1'b0;
      PCout      <= 1'b0;
      MARin      <= 1'b0;
      IncPC      <= 1'b0;
      Zin        <= 1'b0;
      Read       <= 1'b0;
      MDRin      <= 1'b0;
      pcin_r     <= 1'b0;
      MDRout     <= 1'b0;
      IRin       <= 1'b0;
      Gra        <= 1'b0;
      Rout       <= 1'b0;
      CONin      <= 1'b0;
      Yin        <= 1'b0;
      Cout       <= 1'b0;
      ZLOout     <= 1'b0;
    end else begin
      state_r <= nxt_s;
      busy    <= (nxt_s != S_IDLE);
      done    <= (nxt_s == S_END);
      timeout <= (state_r == S_T1) && !mem_ready && stall_limit_s;
      illegal <= (state_r == S_T3) && !CONin;

      if (state_r != S_T1)  wait_cnt_r <= {CW{1'b0}};
      else if (!mem_ready)  wait_cnt_r <= wait_cnt_r + CW'(1);
      else                  wait_cnt_r <= wait_cnt_r;

      if (CONin) CON <= eval_cond(c2_s, bus_in);
      else       CON <= CON;

      PCout  <= 1'b0;
      MARin  <= 1'b0;
      IncPC  <= 1'b0;
      Zin    <= 1'b0;
      Read   <= 1'b0;
      MDRin  <= 1'b0;
      pcin_r <= 1'b0;
      MDRout <= 1'b0;
      IRin   <= 1'b0;
      Gra    <= 1'b0;
      Rout   <= 1'b0;
      CONin  <= 1'b0;
      Yin    <= 1'b0;
      Cout   <= 1'b0;
      ZLOout <= 1'b0;
      case (nxt_s)
        S_T0: begin
          PCout <= 1'b1;
          MARin <= 1'b1;
          IncPC <= 1'b1;
          Zin   <= 1'b1;
        end
        S_T1: begin
          Read  <= 1'b1;
          MDRin <= 1'b1;
        end
        S_T2: begin
          MDRout <= 1'b1;
          IRin   <= 1'b1;
        end
        S_T3: begin
          Gra   <= (opcode_s == OPC_BRANCH);
          Rout  <= (opcode_s == OPC_BRANCH);
          CONin <= (opcode_s == OPC_BRANCH);
        end
        S_T4: begin
          PCout <= 1'b1;
          Yin   <= 1'b1;
        end
        S_T5: begin
          Cout <= 1'b1;
          Zin  <= 1'b1;
        end
        S_T6: begin
          ZLOout <= 1'b1;
          pcin_r <= CON;
        end
        default: begin
          PCout <= 1'b0;
        end
      endcase
    end
  end

endmodule
